pipe_stage_skid: RTL and testbench

Parametrised pipeline stage register for the pipelined CPU: the generalised successor of the fixed PC/instruction stage latches. It carries a DATA_W-bit payload between two pipeline stages with a valid/ready handshake, a synchronous flush that injects a bubble, and an optional two-entry skid buffer. The skid buffer makes in_ready a registered signal, which cuts the combinational stall path between adjacent stages. One instance sits between each pair of stages (IF/ID, ID/EX, ...), with the payload packed by the instantiating stage.

---
 rtl/pipe_pkg.sv | 13 +
 rtl/pipe_stage_skid.sv | 111 +++++++++++
 tb/tb_pipe_stage_skid.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage registers.
package pipe_pkg;

  // Encoding equals the number of held entries, so occupancy is the raw state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  localparam logic [31:0] RV32_NOP = 32'h0000_0013;

endpackage

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage register with flush-to-bubble and an optional two-entry skid
// buffer that makes in_ready a registered signal.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W     = 64,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter int unsigned       SKID       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  pipe_state_t       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_data;
  logic              in_fire, out_fire;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    if (flush) begin
      // Anything accepted this cycle is discarded; upstream re-fetches after the redirect.
      state_d = EMPTY;
      main_d  = BUBBLE_VAL;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            // Only reachable with the skid buffer: downstream stalled while we still accepted.
            state_d = TWO;
          end else if (out_fire) begin
            state_d = EMPTY;
            main_d  = BUBBLE_VAL;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_data;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = BUBBLE_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  if (SKID != 0) begin : g_skid
    logic [DATA_W-1:0] skid_q;
    logic              ready_q;

    always_ff @(posedge clk) begin
      if (rst || flush) begin
        skid_q <= BUBBLE_VAL;
      end else if ((state_q == ONE) && in_fire && !out_fire) begin
        skid_q <= in_data;
      end
    end

    // Registered ready: no combinational path from out_ready to in_ready.
    always_ff @(posedge clk) begin
      if (rst) begin
        ready_q <= 1'b1;
      end else begin
        ready_q <= (state_d != TWO);
      end
    end

    assign skid_data = skid_q;
    assign in_ready  = ready_q;
  end else begin : g_comb
    assign skid_data = BUBBLE_VAL;
    assign in_ready  = out_ready | ~out_valid;
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed vector tables plus a random scoreboard run for both SKID settings.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam logic [31:0] BUB = RV32_NOP;

  typedef struct {
    logic        flush;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        rdy;
    logic        ov;
    logic [31:0] od;
    logic [1:0]  occ;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  logic        s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [31:0] s_in_data, s_out_data;
  logic [1:0]  s_occ;

  logic        c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [31:0] c_in_data, c_out_data;
  logic [1:0]  c_occ;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(32), .BUBBLE_VAL(RV32_NOP), .SKID(1)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (s_flush),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_data   (s_in_data),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_data  (s_out_data),
    .occupancy (s_occ)
  );

  pipe_stage_skid #(.DATA_W(32), .BUBBLE_VAL(RV32_NOP), .SKID(0)) u_comb (
    .clk       (clk),
    .rst       (rst),
    .flush     (c_flush),
    .in_valid  (c_in_valid),
    .in_ready  (c_in_ready),
    .in_data   (c_in_data),
    .out_valid (c_out_valid),
    .out_ready (c_out_ready),
    .out_data  (c_out_data),
    .occupancy (c_occ)
  );

  function automatic vec_t mk(logic fl, logic iv, logic [31:0] d, logic ordy,
                              logic rdy, logic ov, logic [31:0] od, logic [1:0] occ);
    vec_t v;
    v.flush = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.rdy = rdy; v.ov = ov; v.od = od; v.occ = occ;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_s(input logic fl, input logic iv, input logic [31:0] d, input logic ordy);
    s_flush = fl; s_in_valid = iv; s_in_data = d; s_out_ready = ordy;
  endtask

  task automatic drive_c(input logic fl, input logic iv, input logic [31:0] d, input logic ordy);
    c_flush = fl; c_in_valid = iv; c_in_data = d; c_out_ready = ordy;
  endtask

  task automatic check_s(input string tag, input logic rdy, input logic ov, input logic [31:0] od,
                         input logic [1:0] occ);
    check({tag, " skid in_ready"}, 32'(s_in_ready), 32'(rdy));
    check({tag, " skid out_valid"}, 32'(s_out_valid), 32'(ov));
    check({tag, " skid out_data"}, s_out_data, od);
    check({tag, " skid occupancy"}, 32'(s_occ), 32'(occ));
  endtask

  task automatic check_c(input string tag, input logic rdy, input logic ov, input logic [31:0] od,
                         input logic [1:0] occ);
    check({tag, " comb in_ready"}, 32'(c_in_ready), 32'(rdy));
    check({tag, " comb out_valid"}, 32'(c_out_valid), 32'(ov));
    check({tag, " comb out_data"}, c_out_data, od);
    check({tag, " comb occupancy"}, 32'(c_occ), 32'(occ));
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t sv[24];
  vec_t cv[9];
  logic [31:0] sq[$];
  logic [31:0] cq[$];

  initial begin
    // SKID=1: stream, skid fill, flush in TWO, flush with in_fire, drain to bubble.
    sv[0]  = mk(0, 1, 32'h1,  1, 1, 0, BUB,    0);
    sv[1]  = mk(0, 1, 32'h2,  1, 1, 1, 32'h1,  1);
    sv[2]  = mk(0, 1, 32'h3,  1, 1, 1, 32'h2,  1);
    sv[3]  = mk(0, 1, 32'h4,  1, 1, 1, 32'h3,  1);
    sv[4]  = mk(0, 1, 32'h5,  1, 1, 1, 32'h4,  1);
    sv[5]  = mk(0, 0, 32'h0,  1, 1, 1, 32'h5,  1);
    sv[6]  = mk(0, 0, 32'h0,  0, 1, 0, BUB,    0);
    sv[7]  = mk(0, 1, 32'hA,  1, 1, 0, BUB,    0);
    sv[8]  = mk(0, 1, 32'hB,  0, 1, 1, 32'hA,  1);
    sv[9]  = mk(0, 1, 32'hC,  0, 0, 1, 32'hA,  2);
    sv[10] = mk(0, 1, 32'hC,  0, 0, 1, 32'hA,  2);
    sv[11] = mk(0, 1, 32'hC,  1, 0, 1, 32'hA,  2);
    sv[12] = mk(0, 1, 32'hC,  1, 1, 1, 32'hB,  1);
    sv[13] = mk(0, 0, 32'h0,  1, 1, 1, 32'hC,  1);
    sv[14] = mk(0, 0, 32'h0,  0, 1, 0, BUB,    0);
    sv[15] = mk(0, 1, 32'h10, 0, 1, 0, BUB,    0);
    sv[16] = mk(0, 1, 32'h11, 0, 1, 1, 32'h10, 1);
    sv[17] = mk(1, 1, 32'h12, 0, 0, 1, 32'h10, 2);
    sv[18] = mk(0, 0, 32'h0,  1, 1, 0, BUB,    0);
    sv[19] = mk(1, 1, 32'h12, 1, 1, 0, BUB,    0);
    sv[20] = mk(0, 0, 32'h0,  1, 1, 0, BUB,    0);
    sv[21] = mk(0, 1, 32'h55, 0, 1, 0, BUB,    0);
    sv[22] = mk(0, 0, 32'h0,  1, 1, 1, 32'h55, 1);
    sv[23] = mk(0, 0, 32'h0,  1, 1, 0, BUB,    0);
    // SKID=0: in_ready tracks out_ready while holding an entry.
    cv[0]  = mk(0, 1, 32'h21, 0, 1, 0, BUB,    0);
    cv[1]  = mk(0, 1, 32'h22, 1, 1, 1, 32'h21, 1);
    cv[2]  = mk(0, 1, 32'h23, 0, 0, 1, 32'h22, 1);
    cv[3]  = mk(0, 1, 32'h23, 1, 1, 1, 32'h22, 1);
    cv[4]  = mk(0, 0, 32'h0,  0, 0, 1, 32'h23, 1);
    cv[5]  = mk(0, 0, 32'h0,  1, 1, 1, 32'h23, 1);
    cv[6]  = mk(0, 0, 32'h0,  0, 1, 0, BUB,    0);
    cv[7]  = mk(1, 1, 32'h24, 0, 1, 0, BUB,    0);
    cv[8]  = mk(0, 0, 32'h0,  0, 1, 0, BUB,    0);

    rst = 1'b1;
    drive_s(0, 0, 32'h0, 0);
    drive_c(0, 0, 32'h0, 0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check_s("reset", 1, 0, BUB, 0);
    check_c("reset", 1, 0, BUB, 0);
    next_cycle();

    foreach (sv[i]) begin
      drive_s(sv[i].flush, sv[i].iv, sv[i].d, sv[i].ordy);
      @(negedge clk);
      check_s($sformatf("vec%0d", i), sv[i].rdy, sv[i].ov, sv[i].od, sv[i].occ);
      next_cycle();
    end
    drive_s(0, 0, 32'h0, 0);

    foreach (cv[i]) begin
      drive_c(cv[i].flush, cv[i].iv, cv[i].d, cv[i].ordy);
      @(negedge clk);
      check_c($sformatf("vec%0d", i), cv[i].rdy, cv[i].ov, cv[i].od, cv[i].occ);
      next_cycle();
    end
    drive_c(0, 0, 32'h0, 0);

    // Reset mid-stream while full and handshaking: stage empties regardless.
    drive_s(0, 1, 32'h31, 0);
    next_cycle();
    drive_s(0, 1, 32'h32, 0);
    next_cycle();
    @(negedge clk);
    check_s("pre-rst full", 0, 1, 32'h31, 2);
    next_cycle();
    drive_s(0, 1, 32'h33, 1);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    drive_s(0, 0, 32'h0, 0);
    @(negedge clk);
    check_s("mid rst", 1, 0, BUB, 0);
    next_cycle();

    // Random traffic against a FIFO model for both configurations.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic sf, si, so, cf, ci, co;
      logic [31:0] sd, cd;
      logic s_rdy_m, c_rdy_m;
      sf = ($urandom_range(99) < 2); si = $urandom_range(1); so = $urandom_range(1);
      cf = ($urandom_range(99) < 2); ci = $urandom_range(1); co = $urandom_range(1);
      sd = $urandom; cd = $urandom;
      drive_s(sf, si, sd, so);
      drive_c(cf, ci, cd, co);
      s_rdy_m = (sq.size() != 2);
      c_rdy_m = co || (cq.size() == 0);
      @(negedge clk);
      check_s("rand", s_rdy_m, sq.size() != 0, (sq.size() != 0) ? sq[0] : BUB,
              2'(sq.size()));
      check_c("rand", c_rdy_m, cq.size() != 0, (cq.size() != 0) ? cq[0] : BUB,
              2'(cq.size()));
      if (sf) begin
        sq.delete();
      end else begin
        if (so && sq.size() != 0) void'(sq.pop_front());
        if (si && s_rdy_m) sq.push_back(sd);
      end
      if (cf) begin
        cq.delete();
      end else begin
        if (co && cq.size() != 0) void'(cq.pop_front());
        if (ci && c_rdy_m) cq.push_back(cd);
      end
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
